// File: rtl/seizure_pkg.sv
// seizure_pkg: shared status encoding and default frame geometry
package seizure_pkg;
    localparam int DEFAULT_DATA_WIDTH    = 16;
    localparam int DEFAULT_FEATURE_COUNT = 178;
    typedef enum logic [1:0] {
        STATUS_IDLE       = 2'b00,
        STATUS_PROCESSING = 2'b01,
        STATUS_DONE       = 2'b10,
        STATUS_ERROR      = 2'b11
    } status_e;
endpackage

// File: rtl/seizure_timeout_counter.sv
// seizure_timeout_counter: saturating cycle counter flagging the last allowed cycle
module seizure_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);
    localparam logic [W-1:0] MAX   = W'(TIMEOUT_CYCLES);
    logic [W-1:0] cnt_q, cnt_d;
    // expired marks the final permitted cycle so the FSM leaves exactly TIMEOUT_CYCLES cycles after entry
    assign expired = enable && cnt_q >= LIMIT;
    always_comb begin
        cnt_d = clear ? '0 : (enable && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/seizure_frame_responder.sv
// seizure_frame_responder: latches an EEG frame, streams it to the feature core, and reports the core result
module seizure_frame_responder
    import seizure_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int FEATURE_COUNT  = DEFAULT_FEATURE_COUNT,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] eeg_data [FEATURE_COUNT],
    output logic                  system_ready,
    output logic                  result_valid,
    output logic                  seizure_detected,
    output logic [15:0]           detection_confidence,
    output logic [1:0]            system_status,
    output logic                  smp_valid,
    output logic [DATA_WIDTH-1:0] smp_data,
    output logic                  smp_last,
    input  logic                  smp_ready,
    input  logic                  core_done,
    input  logic                  core_seizure,
    input  logic [15:0]           core_confidence
);
    localparam int IW = $clog2(FEATURE_COUNT);
    localparam logic [IW-1:0] LAST = IW'(FEATURE_COUNT - 1);
    localparam logic [2:0] S_IDLE = 3'd0, S_STREAM = 3'd1, S_WAIT = 3'd2, S_DONE = 3'd3, S_ERROR = 3'd4;
    logic [2:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  result_valid_q, result_valid_d;
    logic                  seizure_q, seizure_d;
    logic [15:0]           conf_q, conf_d;
    logic [DATA_WIDTH-1:0] frame_q [FEATURE_COUNT];
    logic [DATA_WIDTH-1:0] frame_d [FEATURE_COUNT];
    logic                  in_stream, in_wait, accept, hs, hs_last, expired;
    assign in_stream    = state_q == S_STREAM;
    assign in_wait      = state_q == S_WAIT;
    assign system_ready = state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR;
    assign accept       = data_valid && system_ready;
    assign hs           = in_stream && smp_ready;
    assign hs_last      = hs && idx_q == LAST;
    assign smp_valid    = in_stream;
    assign smp_data     = in_stream ? frame_q[idx_q] : '0;
    assign smp_last     = in_stream && idx_q == LAST;
    assign result_valid         = result_valid_q;
    assign seizure_detected     = seizure_q;
    assign detection_confidence = conf_q;
    assign system_status = state_q == S_IDLE ? STATUS_IDLE
                         : (in_stream || in_wait) ? STATUS_PROCESSING
                         : state_q == S_DONE ? STATUS_DONE : STATUS_ERROR;
    seizure_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (hs_last),
        .enable  (in_wait),
        .expired (expired)
    );
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        result_valid_d = result_valid_q;
        seizure_d      = seizure_q;
        conf_d         = conf_q;
        frame_d        = frame_q;
        if (accept) begin
            frame_d        = eeg_data;
            idx_d          = '0;
            result_valid_d = 1'b0;
            state_d        = S_STREAM;
        end else if (hs_last) begin
            state_d = S_WAIT;
        end else if (hs) begin
            idx_d = idx_q + 1'b1;
        end else if (in_wait && core_done) begin
            seizure_d      = core_seizure;
            conf_d         = core_confidence;
            result_valid_d = 1'b1;
            state_d        = S_DONE;
        end else if (in_wait && expired) begin
            state_d = S_ERROR;
        end else if (state_q > S_ERROR) begin
            state_d = S_IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            result_valid_q <= 1'b0;
            seizure_q      <= 1'b0;
            conf_q         <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            result_valid_q <= result_valid_d;
            seizure_q      <= seizure_d;
            conf_q         <= conf_d;
        end
    end
    // frame storage is data-only, so it carries no reset
    always_ff @(posedge clk) frame_q <= frame_d;
endmodule
